// File: rtl/mem_pkg.sv
// Shared definitions for the line data memory.
// Holds the default configuration, the widths derived from it, the fill
// FSM state type and the address helpers used by every file of the block.
package mem_pkg;

  // Default configuration
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_FILL_LAT   = 4;

  // Widths derived from the default configuration
  localparam int WORD_IDX_W = $clog2(DEF_DEPTH);
  localparam int OFF_W      = $clog2(DEF_LINE_WORDS);
  localparam int LINE_W     = DEF_DATA_W * DEF_LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_WAIT = 2'd1,
    FILL_RESP = 2'd2
  } fill_state_e;

  // Word index of a byte address; addresses beyond the array wrap.
  function automatic int unsigned word_idx(input logic [63:0] addr,
                                           input int unsigned depth);
    return 32'((addr >> 2) & 64'(depth - 1));
  endfunction

  // First word of the line holding word idx (lines align to line_words).
  function automatic int unsigned line_base(input int unsigned idx,
                                            input int unsigned line_words);
    return idx & ~(line_words - 1);
  endfunction

endpackage

// File: rtl/line_data_memory_if.sv
// Bus bundle between the load/store unit + L1 cache (master) and the
// line data memory (slave): word load, word store with line-update echo,
// line fill with ready/valid, line write-back with ready.
interface line_data_memory_if
  import mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
);
  localparam int LW   = DATA_W * LINE_WORDS;
  localparam int BE_W = DATA_W / 8;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_data_valid;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata;
  logic [BE_W-1:0]   st_be;
  logic              st_line_upd;
  logic [ADDR_W-1:0] st_line_addr;
  logic [LW-1:0]     st_line_data;

  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_ready;
  logic              fill_valid;
  logic [LW-1:0]     fill_data;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [LW-1:0]     wb_data;
  logic              wb_ready;

  modport master (
    output ld_valid, ld_addr, st_valid, st_addr, st_wdata, st_be,
           fill_req, fill_addr, wb_valid, wb_addr, wb_data,
    input  ld_data, ld_data_valid, st_line_upd, st_line_addr, st_line_data,
           fill_ready, fill_valid, fill_data, wb_ready
  );

  modport slave (
    input  ld_valid, ld_addr, st_valid, st_addr, st_wdata, st_be,
           fill_req, fill_addr, wb_valid, wb_addr, wb_data,
    output ld_data, ld_data_valid, st_line_upd, st_line_addr, st_line_data,
           fill_ready, fill_valid, fill_data, wb_ready
  );

endinterface

// File: rtl/mem_byte_array.sv
// Storage for the line data memory.
// Ports:
//   st_*  : byte-enabled word write
//   wb_*  : whole-line write; store lanes win on overlap
//   rd_*  : registered word read
//   la_*  : registered line read (store echo)
//   lb_*  : registered line read (fill response)
// All reads are write-first: they see the writes of the same edge.
// Read registers hold when their enable is low and clear on reset; the
// array contents are never cleared.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int LW        = DATA_W * LINE_WORDS,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_en,
  input  logic [IDX_W-1:0]  st_idx,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic [BE_W-1:0]   st_be,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_base,
  input  logic [LW-1:0]     wb_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              la_en,
  input  logic [IDX_W-1:0]  la_base,
  output logic [LW-1:0]     la_data,
  input  logic              lb_en,
  input  logic [IDX_W-1:0]  lb_base,
  output logic [LW-1:0]     lb_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [LW-1:0]     la_data_q, la_data_d;
  logic [LW-1:0]     lb_data_q, lb_data_d;
  logic [LW-1:0]     la_next, lb_next;

  // Contents of word idx as they will be after this edge's writes.
  function automatic logic [DATA_W-1:0] word_next(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] w;
    int                off;
    w   = mem[idx];
    off = 32'(idx) & (LINE_WORDS - 1);
    if (wb_en && (IDX_W'(line_base(32'(idx), LINE_WORDS)) == wb_base)) begin
      w = wb_data[off*DATA_W +: DATA_W];
    end
    if (st_en && (idx == st_idx)) begin
      for (int b = 0; b < BE_W; b++) begin
        if (st_be[b]) w[b*8 +: 8] = st_wdata[b*8 +: 8];
      end
    end
    return w;
  endfunction

  // Line bases have their offset bits clear, so OR-ing in the word number
  // addresses each word of the line.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line_rd
      assign la_next[gi*DATA_W +: DATA_W] = word_next(la_base | IDX_W'(gi));
      assign lb_next[gi*DATA_W +: DATA_W] = word_next(lb_base | IDX_W'(gi));
    end
  endgenerate

  // Line write first, store second: the later assignment wins for
  // the bytes the store enables.
  always_ff @(posedge clk) begin
    if (wb_en) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        mem[wb_base | IDX_W'(w)] <= wb_data[w*DATA_W +: DATA_W];
      end
    end
    if (st_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (st_be[b]) mem[st_idx][b*8 +: 8] <= st_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    la_data_d = la_data_q;
    lb_data_d = lb_data_q;
    if (rd_en) rd_data_d = word_next(rd_idx);
    if (la_en) la_data_d = la_next;
    if (lb_en) lb_data_d = lb_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      la_data_q <= '0;
      lb_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      la_data_q <= la_data_d;
      lb_data_q <= lb_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign la_data = la_data_q;
  assign lb_data = lb_data_q;

endmodule

// File: rtl/line_data_memory.sv
// Word/line data memory below the load/store unit and the L1 data cache.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of line_data_memory_if (load, store with
//                line-update echo, line fill, line write-back)
// Loads and stores are never stalled. Fills and write-backs share one FSM
// (IDLE / FILL_WAIT / FILL_RESP); write-back wins over a fill in IDLE.
module line_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int FILL_LAT   = DEF_FILL_LAT
) (
  input  logic         clk,
  input  logic         rst_n,
  line_data_memory_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FILL_LAT + 1);
  localparam int LW    = DATA_W * LINE_WORDS;

  fill_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  fill_base_q, fill_base_d;
  logic              ld_data_valid_q, ld_data_valid_d;
  logic              st_line_upd_q, st_line_upd_d;
  logic [ADDR_W-1:0] st_line_addr_q, st_line_addr_d;
  logic              fill_valid_q, fill_valid_d;

  logic [IDX_W-1:0]  ld_idx, st_idx, st_base, fill_base_in, wb_base;
  logic [IDX_W-1:0]  fill_rd_base;
  logic              st_en, wb_en, fill_fire;
  logic [LW-1:0]     st_line_rd, fill_line_rd;
  logic [DATA_W-1:0] ld_rd;

  assign ld_idx       = IDX_W'(word_idx(64'(bus.ld_addr), DEPTH));
  assign st_idx       = IDX_W'(word_idx(64'(bus.st_addr), DEPTH));
  assign st_base      = IDX_W'(line_base(32'(st_idx), LINE_WORDS));
  assign fill_base_in = IDX_W'(line_base(word_idx(64'(bus.fill_addr), DEPTH), LINE_WORDS));
  assign wb_base      = IDX_W'(line_base(word_idx(64'(bus.wb_addr), DEPTH), LINE_WORDS));

  // A store with no enabled bytes is a no-op and raises no echo.
  assign st_en = bus.st_valid && (|bus.st_be);

  // Fill FSM. The counter is loaded with FILL_LAT-1 on acceptance; the
  // response is captured on the edge where it reaches 0, so fill_valid is
  // seen FILL_LAT cycles after acceptance while the FSM sits in FILL_RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_base_d  = fill_base_q;
    fill_rd_base = fill_base_q;
    fill_fire    = 1'b0;
    wb_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wb_valid) begin
          wb_en = 1'b1;
        end else if (bus.fill_req) begin
          fill_base_d = fill_base_in;
          if (FILL_LAT == 1) begin
            fill_fire    = 1'b1;
            fill_rd_base = fill_base_in;
            state_d      = FILL_RESP;
          end else begin
            cnt_d   = CNT_W'(FILL_LAT - 1);
            state_d = FILL_WAIT;
          end
        end
      end
      FILL_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          fill_fire = 1'b1;
          state_d   = FILL_RESP;
        end
      end
      FILL_RESP: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_data_valid_d = bus.ld_valid;
    st_line_upd_d   = st_en;
    fill_valid_d    = fill_fire;
    st_line_addr_d  = st_line_addr_q;
    if (st_en) st_line_addr_d = ADDR_W'({st_base, 2'b00});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      fill_base_q     <= '0;
      ld_data_valid_q <= 1'b0;
      st_line_upd_q   <= 1'b0;
      st_line_addr_q  <= '0;
      fill_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fill_base_q     <= fill_base_d;
      ld_data_valid_q <= ld_data_valid_d;
      st_line_upd_q   <= st_line_upd_d;
      st_line_addr_q  <= st_line_addr_d;
      fill_valid_q    <= fill_valid_d;
    end
  end

  mem_byte_array #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_en    (st_en),
    .st_idx   (st_idx),
    .st_wdata (bus.st_wdata),
    .st_be    (bus.st_be),
    .wb_en    (wb_en),
    .wb_base  (wb_base),
    .wb_data  (bus.wb_data),
    .rd_en    (bus.ld_valid),
    .rd_idx   (ld_idx),
    .rd_data  (ld_rd),
    .la_en    (st_en),
    .la_base  (st_base),
    .la_data  (st_line_rd),
    .lb_en    (fill_fire),
    .lb_base  (fill_rd_base),
    .lb_data  (fill_line_rd)
  );

  assign bus.ld_data       = ld_rd;
  assign bus.ld_data_valid = ld_data_valid_q;
  assign bus.st_line_upd   = st_line_upd_q;
  assign bus.st_line_addr  = st_line_addr_q;
  assign bus.st_line_data  = st_line_rd;
  assign bus.fill_ready    = (state_q == IDLE);
  assign bus.wb_ready      = (state_q == IDLE);
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_data     = fill_line_rd;

endmodule

// File: tb/tb_line_data_memory.sv
// Self-checking bench for line_data_memory: directed scenarios followed by
// randomized traffic, all checked against a word-array reference model.
module tb_line_data_memory;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int DEPTH      = 256;
  localparam int LINE_WORDS = 8;
  localparam int FILL_LAT   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_data_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) bus ();

  line_data_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .LINE_WORDS(LINE_WORDS), .FILL_LAT(FILL_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model
  logic [31:0]  mdl [DEPTH];
  bit           pend;
  int           acc_cyc;
  int           fill_base;
  int           cyc;
  logic [255:0] last_fill;
  logic [255:0] last_stline;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic int lbase(input int i);
    return i - (i % LINE_WORDS);
  endfunction

  function automatic logic [255:0] snap(input int base);
    logic [255:0] s;
    for (int k = 0; k < LINE_WORDS; k++) s[k*32 +: 32] = mdl[base + k];
    return s;
  endfunction

  task automatic idle_inputs();
    bus.ld_valid = 0; bus.ld_addr = '0;
    bus.st_valid = 0; bus.st_addr = '0; bus.st_wdata = '0; bus.st_be = '0;
    bus.fill_req = 0; bus.fill_addr = '0;
    bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
  endtask

  // One clock cycle with the currently driven inputs: predict, clock, compare.
  task automatic do_cycle();
    bit           exp_ready, exp_ldv, st_fire, fire;
    logic [31:0]  exp_ld;
    logic [31:0]  exp_staddr;
    int           si, lb;
    exp_ld = '0; exp_staddr = '0;
    if (pend && cyc >= acc_cyc + FILL_LAT + 1) pend = 0;
    exp_ready = !pend;
    check("fill_ready", bus.fill_ready, exp_ready);
    check("wb_ready", bus.wb_ready, exp_ready);

    if (bus.wb_valid && exp_ready) begin
      lb = lbase(widx(bus.wb_addr));
      for (int k = 0; k < LINE_WORDS; k++) mdl[lb + k] = bus.wb_data[k*32 +: 32];
    end
    st_fire = bus.st_valid && (bus.st_be != 0);
    if (st_fire) begin
      si = widx(bus.st_addr);
      for (int b = 0; b < 4; b++)
        if (bus.st_be[b]) mdl[si][b*8 +: 8] = bus.st_wdata[b*8 +: 8];
      last_stline = snap(lbase(si));
      exp_staddr  = 32'(lbase(si) * 4);
    end
    exp_ldv = bus.ld_valid;
    if (exp_ldv) exp_ld = mdl[widx(bus.ld_addr)];

    if (exp_ready && !bus.wb_valid && bus.fill_req) begin
      pend = 1; acc_cyc = cyc; fill_base = lbase(widx(bus.fill_addr));
    end
    fire = pend && (cyc == acc_cyc + FILL_LAT - 1);
    if (fire) last_fill = snap(fill_base);

    @(posedge clk); #1;
    cyc++;
    check("ld_data_valid", bus.ld_data_valid, exp_ldv);
    if (exp_ldv) check("ld_data", bus.ld_data, exp_ld);
    check("st_line_upd", bus.st_line_upd, st_fire);
    if (st_fire) check("st_line_addr", bus.st_line_addr, exp_staddr);
    check("st_line_data", bus.st_line_data, last_stline);
    check("fill_valid", bus.fill_valid, fire);
    check("fill_data", bus.fill_data, last_fill);
  endtask

  task automatic check_reset_outputs();
    check("rst_ld_data", bus.ld_data, 0);
    check("rst_ld_data_valid", bus.ld_data_valid, 0);
    check("rst_st_line_upd", bus.st_line_upd, 0);
    check("rst_st_line_addr", bus.st_line_addr, 0);
    check("rst_st_line_data", bus.st_line_data, 0);
    check("rst_fill_valid", bus.fill_valid, 0);
    check("rst_fill_data", bus.fill_data, 0);
    check("rst_fill_ready", bus.fill_ready, 1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    pend = 0; last_fill = '0; last_stline = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_inputs();
    bus.st_valid = 1; bus.st_addr = a; bus.st_wdata = d; bus.st_be = be;
  endtask

  logic [255:0] pat;

  initial begin
    cyc = 0; pend = 0; acc_cyc = 0; fill_base = 0;
    last_fill = '0; last_stline = '0;
    idle_inputs();
    apply_reset();

    // Initialise every line through write-back so the model is fully known.
    for (int l = 0; l < DEPTH / LINE_WORDS; l++) begin
      idle_inputs();
      bus.wb_valid = 1; bus.wb_addr = 32'(l * LINE_WORDS * 4);
      for (int k = 0; k < LINE_WORDS; k++) bus.wb_data[k*32 +: 32] = $urandom;
      do_cycle();
    end

    // Full-word store and its line echo, then load it back.
    store(32'h40, 32'hDEADBEEF, 4'hF); do_cycle();
    check("dir_stline_w0", bus.st_line_data[31:0], 32'hDEADBEEF);
    check("dir_stline_addr", bus.st_line_addr, 32'h40);
    idle_inputs(); bus.ld_valid = 1; bus.ld_addr = 32'h40; do_cycle();
    check("dir_ld_40", bus.ld_data, 32'hDEADBEEF);

    // Byte store with a same-cycle load (write-first), then a plain load.
    store(32'h44, 32'h11223344, 4'hF); do_cycle();
    store(32'h44, 32'h000000AA, 4'b0001); bus.ld_valid = 1; bus.ld_addr = 32'h44; do_cycle();
    check("dir_ld_wfirst", bus.ld_data, 32'h112233AA);
    idle_inputs(); bus.ld_valid = 1; bus.ld_addr = 32'h44; do_cycle();
    check("dir_ld_44", bus.ld_data, 32'h112233AA);

    // Fill of line 0x40 with a store landing during FILL_WAIT.
    idle_inputs(); bus.fill_req = 1; bus.fill_addr = 32'h5C; do_cycle();
    check("dir_fill_busy", bus.fill_ready, 0);
    store(32'h48, 32'h00000077, 4'hF); do_cycle();
    idle_inputs();
    repeat (FILL_LAT - 2) do_cycle();
    check("dir_fill_vld", bus.fill_valid, 1);
    check("dir_fill_w0", bus.fill_data[31:0], 32'hDEADBEEF);
    check("dir_fill_w1", bus.fill_data[63:32], 32'h112233AA);
    check("dir_fill_w2", bus.fill_data[95:64], 32'h00000077);
    do_cycle();
    check("dir_fill_ready_back", bus.fill_ready, 1);

    // Write-back and fill together: write-back first, fill returns its line.
    for (int k = 0; k < LINE_WORDS; k++) pat[k*32 +: 32] = 32'hA0000000 + 32'(k);
    idle_inputs();
    bus.wb_valid = 1; bus.wb_addr = 32'h80; bus.wb_data = pat;
    bus.fill_req = 1; bus.fill_addr = 32'h84;
    do_cycle();
    check("dir_wb_first_ready", bus.fill_ready, 1);
    bus.wb_valid = 0; do_cycle();
    idle_inputs();
    repeat (FILL_LAT - 1) do_cycle();
    check("dir_wbfill_vld", bus.fill_valid, 1);
    check("dir_wbfill_data", bus.fill_data, pat);
    repeat (2) do_cycle();

    // Reset two cycles into a fill: aborted, no response afterwards.
    idle_inputs(); bus.fill_req = 1; bus.fill_addr = 32'hC0; do_cycle();
    idle_inputs(); do_cycle();
    apply_reset();
    repeat (FILL_LAT + 2) do_cycle();

    // Store with no byte enables: no echo, memory unchanged.
    store(32'h40, 32'h55555555, 4'h0); do_cycle();
    check("dir_be0_no_upd", bus.st_line_upd, 0);
    idle_inputs(); bus.ld_valid = 1; bus.ld_addr = 32'h40; do_cycle();
    check("dir_be0_unchanged", bus.ld_data, 32'hDEADBEEF);

    // Address 0x400 wraps to word 0.
    store(32'h400, 32'hCAFEF00D, 4'hF); do_cycle();
    check("dir_wrap_addr", bus.st_line_addr, 32'h0);
    idle_inputs(); bus.ld_valid = 1; bus.ld_addr = 32'h0; do_cycle();
    check("dir_wrap_ld", bus.ld_data, 32'hCAFEF00D);

    // Randomized traffic concentrated on 8 lines, upper address bits random.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      bus.ld_valid  = 1'($urandom);
      bus.ld_addr   = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63) << 2) | ($urandom % 4);
      bus.st_valid  = 1'($urandom);
      bus.st_addr   = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63) << 2);
      bus.st_wdata  = $urandom;
      bus.st_be     = 4'($urandom);
      bus.wb_valid  = ($urandom % 4 == 0);
      bus.wb_addr   = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63) << 2);
      for (int k = 0; k < LINE_WORDS; k++) bus.wb_data[k*32 +: 32] = $urandom;
      bus.fill_req  = ($urandom % 3 == 0);
      bus.fill_addr = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63) << 2);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_data_memory.md
Name: line_data_memory

Overview:
Parametrised word/line data memory serving the ROB load path, the store path and the cache line-fill and write-back paths. Every path is synchronous. Line-fill requests use a ready/valid handshake and a programmable latency counter. A store raises a one-cycle registered line-update pulse carrying the post-write line so the cache can stay coherent. Sits below the load/store unit and the L1 data cache.

Parameters:
DATA_W, 32, word width in bits, multiple of 8
ADDR_W, 32, byte-address width
DEPTH, 256, number of words; power of 2
LINE_WORDS, 8, words per cache line; power of 2, <= DEPTH
FILL_LAT, 4, cycles from fill acceptance to fill_valid; >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  word load request
ld_addr  in  ADDR_W  load byte address
ld_data  out  DATA_W  load result
ld_data_valid  out  1  ld_data valid; follows ld_valid by one cycle
st_valid  in  1  word store request
st_addr  in  ADDR_W  store byte address
st_wdata  in  DATA_W  store data
st_be  in  DATA_W/8  byte enables
st_line_upd  out  1  one-cycle pulse: a store updated a line
st_line_addr  out  ADDR_W  byte address of the line base for that update
st_line_data  out  DATA_W*LINE_WORDS  post-write line; word 0 at LSBs
fill_req  in  1  line fill request
fill_addr  in  ADDR_W  any byte address inside the requested line
fill_ready  out  1  fill accepted when fill_req && fill_ready
fill_valid  out  1  one-cycle pulse carrying the fill data
fill_data  out  DATA_W*LINE_WORDS  fill line
wb_valid  in  1  line write-back request
wb_addr  in  ADDR_W  write-back line address
wb_data  in  DATA_W*LINE_WORDS  write-back line
wb_ready  out  1  write-back accepted when wb_valid && wb_ready

Behaviour:
- Addressing: word index = addr[ADDR_W-1:2] mod DEPTH; out-of-range addresses wrap, no error.
- Line base = word index with the low log2(LINE_WORDS) bits cleared. Lines are aligned to LINE_WORDS, never to a fixed 4.
- Reset: all outputs go to 0 and the FSM goes to IDLE, with no response pending. The array is not cleared by reset.
- Load: ld_data and ld_data_valid are registered with 1-cycle latency.
  - Load and store to the same word in the same cycle: write-first. ld_data returns the merged new bytes.
- Store: bytes whose st_be bit is set are written at the clock edge. st_be == 0 writes nothing and raises no pulse.
  - The next cycle, st_line_upd = 1 for exactly one cycle, with st_line_addr and st_line_data reflecting the post-write line.
- FSM states IDLE, FILL_WAIT, FILL_RESP:
  - fill_ready = wb_ready = (state == IDLE).
  - IDLE: if wb_valid, write the whole line at the edge and stay in IDLE. wb takes priority over a simultaneous fill_req, and that fill_req stays pending.
  - IDLE: else if fill_req, latch the line base, load the counter with FILL_LAT-1 and go to FILL_WAIT. If FILL_LAT == 1, go directly to FILL_RESP.
  - FILL_WAIT: decrement the counter; at 0 go to FILL_RESP.
  - FILL_RESP: read the array into fill_data, registered, so fill_valid = 1 exactly FILL_LAT cycles after the acceptance edge. Return to IDLE.
  - The fill snapshot is taken at the FILL_RESP read, so stores made during FILL_WAIT are included.
- Store vs write-back in the same cycle to the same word: the store's enabled bytes override the wb_data bytes.
- Reset during FILL_WAIT or FILL_RESP aborts the fill. No fill_valid is produced.
- fill_data and st_line_data hold their last value when their pulse is low.
- Load and store ports are never stalled by the FSM.

Decomposition:
- Package mem_pkg holds:
  - derived widths: WORD_IDX_W = log2(DEPTH), OFF_W = log2(LINE_WORDS), LINE_W = DATA_W*LINE_WORDS
  - FSM state enum
  - helper functions word_idx() and line_base()
- One sub-module, mem_byte_array: the storage with one byte-enabled word write port, one line write port (merged, store lanes winning), one word read port and two line read ports.

Test Plan:
- Reset, then store 0xDEADBEEF to addr 0x40 with be=4'hF. Next cycle st_line_upd=1, st_line_addr=0x40, st_line_data word0=0xDEADBEEF. Load 0x40 -> ld_data=0xDEADBEEF one cycle later.
- Byte store 0x000000AA with be=4'b0001 over 0x11223344 at 0x44 -> load returns 0x112233AA; a same-cycle load also returns 0x112233AA (write-first).
- fill_req with addr 0x5C (line 0x40) at cycle T, FILL_LAT=4 -> fill_ready drops at T+1; fill_valid=1 only at T+4 with 8 words of line 0x40; fill_ready returns at T+5.
- During FILL_WAIT, store 0x77 to 0x48 -> fill_data word2=0x00000077 in the response.
- wb_valid and fill_req asserted together for line 0x80 -> write-back accepted first; the fill accepted the next cycle returns the wb_data line.
- Assert rst_n=0 at T+2 of a fill -> no fill_valid appears; all outputs 0; fill_ready=1 after reset.
- Store with be=0 -> no st_line_upd pulse and memory unchanged.
- Address 0x400 with DEPTH=256 wraps to word 0.
